// File: rtl/seq_alu.sv
// seq_alu: registered valid/ready ALU with single-cycle logic/add/compare ops and an iterative shift-add multiply.
// Define SEQ_ALU_SAT_EN to make ADDS/SUBS/MULS/ADDU/SUBU/MULU saturate on overflow instead of wrapping.
module seq_alu #(
    parameter int DATA_WIDTH = 32,
    parameter int OP_WIDTH   = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [OP_WIDTH-1:0]   op,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] result,
    output logic                  overflow,
    output logic                  busy
);
    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(DATA_WIDTH);
`ifdef SEQ_ALU_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif
    localparam logic [W-1:0] SMAX = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0] SMIN = {1'b1, {(W-1){1'b0}}};
    localparam logic [OP_WIDTH-1:0] OP_ADDS = OP_WIDTH'(0);
    localparam logic [OP_WIDTH-1:0] OP_SUBS = OP_WIDTH'(1);
    localparam logic [OP_WIDTH-1:0] OP_MULS = OP_WIDTH'(2);
    localparam logic [OP_WIDTH-1:0] OP_MAXS = OP_WIDTH'(3);
    localparam logic [OP_WIDTH-1:0] OP_MINS = OP_WIDTH'(4);
    localparam logic [OP_WIDTH-1:0] OP_ADDU = OP_WIDTH'(5);
    localparam logic [OP_WIDTH-1:0] OP_SUBU = OP_WIDTH'(6);
    localparam logic [OP_WIDTH-1:0] OP_MULU = OP_WIDTH'(7);
    localparam logic [OP_WIDTH-1:0] OP_MAXU = OP_WIDTH'(8);
    localparam logic [OP_WIDTH-1:0] OP_MINU = OP_WIDTH'(9);
    localparam logic [OP_WIDTH-1:0] OP_AND  = OP_WIDTH'(10);
    localparam logic [OP_WIDTH-1:0] OP_OR   = OP_WIDTH'(11);
    localparam logic [OP_WIDTH-1:0] OP_XOR  = OP_WIDTH'(12);
    localparam logic [OP_WIDTH-1:0] OP_NOT  = OP_WIDTH'(13);
    localparam logic [OP_WIDTH-1:0] OP_REV  = OP_WIDTH'(14);
    localparam logic [OP_WIDTH-1:0] OP_LTS  = OP_WIDTH'(15);
    localparam logic [OP_WIDTH-1:0] OP_GES  = OP_WIDTH'(16);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_t;

    state_t         r_state, w_state_nxt;
    logic [W-1:0]   r_result;
    logic           r_overflow;
    logic [2*W-1:0] r_mcand;
    logic [W-1:0]   r_mplier;
    logic [2*W-1:0] r_acc;
    logic [CW-1:0]  r_cnt;
    logic           r_neg;
    logic           r_signed;

    logic           w_accept;
    logic           w_is_mul;
    logic           w_muls_op;
    logic [W-1:0]   w_a_mag;
    logic [W-1:0]   w_b_mag;
    logic [W:0]     w_add;
    logic [W:0]     w_sub;
    logic           w_adds_ovf;
    logic           w_subs_ovf;
    logic [W-1:0]   w_ssat;
    logic           w_lts;
    logic           w_ltu;
    logic [W-1:0]   w_rev;
    logic [W-1:0]   w_alu_res;
    logic           w_alu_ovf;
    logic [2*W-1:0] w_acc_nxt;
    logic [2*W-1:0] w_prod;
    logic           w_mul_last;
    logic           w_mul_ovf;
    logic [W-1:0]   w_mul_res;

    assign in_ready  = (r_state == S_IDLE) | ((r_state == S_DONE) & out_ready);
    assign out_valid = r_state == S_DONE;
    assign busy      = r_state == S_MUL;
    assign result    = r_result;
    assign overflow  = r_overflow;

    assign w_accept  = in_valid & in_ready;
    assign w_muls_op = op == OP_MULS;
    assign w_is_mul  = w_muls_op | (op == OP_MULU);
    assign w_a_mag   = (w_muls_op && a[W-1]) ? -a : a;
    assign w_b_mag   = (w_muls_op && b[W-1]) ? -b : b;

    assign w_add      = {1'b0, a} + {1'b0, b};
    assign w_sub      = {1'b0, a} - {1'b0, b};
    assign w_adds_ovf = (a[W-1] == b[W-1]) && (w_add[W-1] != a[W-1]);
    assign w_subs_ovf = (a[W-1] != b[W-1]) && (w_sub[W-1] != a[W-1]);
    // Signed add/sub can only overflow in the direction of a's sign.
    assign w_ssat     = a[W-1] ? SMIN : SMAX;
    assign w_lts      = $signed(a) < $signed(b);
    assign w_ltu      = w_sub[W];

    for (genvar i = 0; i < W; i++) begin : g_rev
        assign w_rev[i] = a[W-1-i];
    end

    always_comb begin
        w_alu_res = '0;
        w_alu_ovf = 1'b0;
        case (op)
            OP_ADDS: begin
                w_alu_ovf = w_adds_ovf;
                w_alu_res = (SAT && w_adds_ovf) ? w_ssat : w_add[W-1:0];
            end
            OP_SUBS: begin
                w_alu_ovf = w_subs_ovf;
                w_alu_res = (SAT && w_subs_ovf) ? w_ssat : w_sub[W-1:0];
            end
            OP_ADDU: begin
                w_alu_ovf = w_add[W];
                w_alu_res = (SAT && w_add[W]) ? '1 : w_add[W-1:0];
            end
            OP_SUBU: begin
                w_alu_ovf = w_ltu;
                w_alu_res = (SAT && w_ltu) ? '0 : w_sub[W-1:0];
            end
            OP_MAXS: w_alu_res = w_lts ? b : a;
            OP_MINS: w_alu_res = ($signed(a) <= $signed(b)) ? a : b;
            OP_MAXU: w_alu_res = w_ltu ? b : a;
            OP_MINU: w_alu_res = (a <= b) ? a : b;
            OP_AND:  w_alu_res = a & b;
            OP_OR:   w_alu_res = a | b;
            OP_XOR:  w_alu_res = a ^ b;
            OP_NOT:  w_alu_res = ~a;
            OP_REV:  w_alu_res = w_rev;
            OP_LTS:  w_alu_res = {{(W-1){1'b0}}, w_lts};
            OP_GES:  w_alu_res = {{(W-1){1'b0}}, ~w_lts};
            OP_MULS, OP_MULU: ;
            default: w_alu_ovf = 1'b1;
        endcase
    end

    // The last iteration folds its partial product and the sign fix into the same edge.
    assign w_acc_nxt  = r_acc + (r_mplier[0] ? r_mcand : '0);
    assign w_prod     = r_neg ? -w_acc_nxt : w_acc_nxt;
    assign w_mul_last = r_cnt == CW'(W-1);
    assign w_mul_ovf  = r_signed ? !((&w_prod[2*W-1:W-1]) | ~(|w_prod[2*W-1:W-1]))
                                 : |w_prod[2*W-1:W];
    assign w_mul_res  = (SAT && w_mul_ovf) ? (r_signed ? (r_neg ? SMIN : SMAX) : '1)
                                           : w_prod[W-1:0];

    always_comb begin
        w_state_nxt = r_state;
        if (w_accept)
            w_state_nxt = w_is_mul ? S_MUL : S_DONE;
        else if (r_state == S_MUL)
            w_state_nxt = w_mul_last ? S_DONE : S_MUL;
        else if (r_state == S_DONE && out_ready)
            w_state_nxt = S_IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_result   <= '0;
            r_overflow <= 1'b0;
            r_mcand    <= '0;
            r_mplier   <= '0;
            r_acc      <= '0;
            r_cnt      <= '0;
            r_neg      <= 1'b0;
            r_signed   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept && w_is_mul) begin
                r_mcand  <= {{W{1'b0}}, w_a_mag};
                r_mplier <= w_b_mag;
                r_acc    <= '0;
                r_cnt    <= '0;
                r_neg    <= w_muls_op & (a[W-1] ^ b[W-1]);
                r_signed <= w_muls_op;
            end else if (w_accept) begin
                r_result   <= w_alu_res;
                r_overflow <= w_alu_ovf;
            end else if (r_state == S_MUL) begin
                r_acc    <= w_acc_nxt;
                r_mcand  <= r_mcand << 1;
                r_mplier <= r_mplier >> 1;
                r_cnt    <= r_cnt + CW'(1);
                if (w_mul_last) begin
                    r_result   <= w_mul_res;
                    r_overflow <= w_mul_ovf;
                end
            end
        end
    end
endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu: scoreboard bench for seq_alu at DATA_WIDTH=32; expectations come from a 64-bit reference model.
module tb_seq_alu;
`ifdef SEQ_ALU_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [4:0]  op = '0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] result;
    logic        overflow;
    logic        busy;

    int n_vec = 0;
    int n_err = 0;
    logic [32:0] sb[$];

    seq_alu #(.DATA_WIDTH(32), .OP_WIDTH(5)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op),
        .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .overflow(overflow), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [32:0] sat_s(input longint t);
        logic [63:0] u;
        logic        v;
        u = t;
        v = (t > 64'sd2147483647) || (t < -64'sd2147483648);
        return {v, (SAT && v) ? ((t < 0) ? 32'h80000000 : 32'h7fffffff) : u[31:0]};
    endfunction

    function automatic logic [32:0] model(input int o, input logic [31:0] x, input logic [31:0] y);
        longint      sx, sy;
        logic [63:0] u;
        logic [31:0] r;
        logic        v;
        sx = $signed(x);
        sy = $signed(y);
        r = '0;
        v = 1'b0;
        u = '0;
        case (o)
            0: {v, r} = sat_s(sx + sy);
            1: {v, r} = sat_s(sx - sy);
            2: {v, r} = sat_s(sx * sy);
            3: r = (sx >= sy) ? x : y;
            4: r = (sx <= sy) ? x : y;
            5: begin u = {32'b0, x} + {32'b0, y}; v = u[32]; r = (SAT && v) ? '1 : u[31:0]; end
            6: begin v = x < y; r = (SAT && v) ? '0 : x - y; end
            7: begin u = {32'b0, x} * {32'b0, y}; v = |u[63:32]; r = (SAT && v) ? '1 : u[31:0]; end
            8: r = (x >= y) ? x : y;
            9: r = (x <= y) ? x : y;
            10: r = x & y;
            11: r = x | y;
            12: r = x ^ y;
            13: r = ~x;
            14: for (int i = 0; i < 32; i++) r[i] = x[31-i];
            15: r = {31'b0, sx < sy};
            16: r = {31'b0, sx >= sy};
            default: v = 1'b1;
        endcase
        return {v, r};
    endfunction

    // Issue one op from IDLE/DONE, scramble inputs after accept, and wait (bounded) for out_valid.
    task automatic run_op(input int o, input logic [31:0] x, input logic [31:0] y,
                          output int lat, output int nb, output logic [32:0] got);
        in_valid = 1'b1; op = 5'(o); a = x; b = y; out_ready = 1'b1;
        sb.push_back(model(o, x, y));
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0; op = 5'($urandom); a = $urandom; b = $urandom;
        lat = 1;
        nb = 0;
        while (!out_valid && lat < 100) begin
            nb += int'(busy);
            @(negedge clk);
            lat++;
        end
        got = {overflow, result};
    endtask

    task automatic test_reset;
        @(negedge clk);
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_out_valid got %b want 0", out_valid); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy got %b want 0", busy); end
        n_vec++; if ({overflow, result} !== 33'h0) begin n_err++; $display("FAIL rst_result got %h want 0", {overflow, result}); end
        rst = 1'b0;
        @(negedge clk);
        n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rst_in_ready got %b want 1", in_ready); end
    endtask

    task automatic test_single_cycle;
        int          ops[16] = '{0, 1, 6, 14, 16, 20, 3, 4, 8, 9, 15, 5, 10, 11, 12, 1};
        logic [31:0] as[16]  = '{32'h3, 32'h0, 32'h3, 32'h3, 32'h3, 32'h5, 32'h80000000, 32'h5,
                                 32'h80000000, 32'hffffffff, 32'hffffffff, 32'hffffffff,
                                 32'hf0f0a5a5, 32'hf0f0a5a5, 32'hf0f0a5a5, 32'h7fffffff};
        logic [31:0] bs[16]  = '{32'h7ffffffd, 32'h80000000, 32'h7ffffffd, 32'h0, 32'h7ffffffd, 32'h6,
                                 32'h1, 32'h5, 32'h1, 32'h2, 32'h0, 32'h2,
                                 32'h0ff05a5a, 32'h0ff05a5a, 32'h0ff05a5a, 32'hffffffff};
        int lat, nb;
        logic [32:0] got, exp;
        for (int i = 0; i < 16; i++) begin
            run_op(ops[i], as[i], bs[i], lat, nb, got);
            exp = sb.pop_front();
            n_vec++; if (lat !== 1 || nb !== 0) begin n_err++; $display("FAIL op%0d_latency got %0d/%0d want 1/0", ops[i], lat, nb); end
            n_vec++; if (got !== exp) begin n_err++; $display("FAIL op%0d_result got %h want %h", ops[i], got, exp); end
        end
        run_op(13, 32'h12345678, 32'h0, lat, nb, got);
        exp = sb.pop_front();
        n_vec++; if (got !== {1'b0, 32'hedcba987}) begin n_err++; $display("FAIL not_result got %h want %h", got, {1'b0, 32'hedcba987}); end
        n_vec++; if (got !== exp) begin n_err++; $display("FAIL not_model got %h want %h", got, exp); end
    endtask

    task automatic test_mul;
        int          ops[6] = '{2, 2, 7, 2, 7, 2};
        logic [31:0] as[6]  = '{32'h3, 32'hfffffffd, 32'hffffffff, 32'h80000000, 32'h00010000, 32'h80000000};
        logic [31:0] bs[6]  = '{32'h7ffffffd, 32'h4, 32'hffffffff, 32'h80000000, 32'h0000ffff, 32'hffffffff};
        int lat, nb;
        logic [32:0] got, exp;
        for (int i = 0; i < 6; i++) begin
            run_op(ops[i], as[i], bs[i], lat, nb, got);
            exp = sb.pop_front();
            n_vec++; if (lat !== 33) begin n_err++; $display("FAIL mul%0d_latency got %0d want 33", i, lat); end
            n_vec++; if (nb !== 32) begin n_err++; $display("FAIL mul%0d_busy got %0d want 32", i, nb); end
            n_vec++; if (got !== exp) begin n_err++; $display("FAIL mul%0d_result got %h want %h", i, got, exp); end
        end
    endtask

    task automatic test_back_to_back;
        int          ops[3] = '{10, 11, 12};
        logic [31:0] x = 32'hc3c3_5a5a;
        logic [31:0] y = 32'h0ff0_33cc;
        logic [32:0] exp, held;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) begin
                exp = sb.pop_front();
                held = exp;
                n_vec++; if (out_valid !== 1'b1 || {overflow, result} !== exp) begin n_err++; $display("FAIL b2b%0d_result got %b/%h want 1/%h", i, out_valid, {overflow, result}, exp); end
            end
            if (i < 3) begin
                n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL b2b%0d_in_ready got %b want 1", i, in_ready); end
                in_valid = 1'b1; op = 5'(ops[i]); a = x; b = y;
                sb.push_back(model(ops[i], x, y));
            end else begin
                in_valid = 1'b0;
                out_ready = 1'b0;
            end
            @(negedge clk);
        end
        for (int i = 0; i < 5; i++) begin
            a = $urandom; b = $urandom;
            n_vec++; if (out_valid !== 1'b1 || in_ready !== 1'b0 || {overflow, result} !== held) begin n_err++; $display("FAIL hold%0d got v=%b r=%b %h want v=1 r=0 %h", i, out_valid, in_ready, {overflow, result}, held); end
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        n_vec++; if (out_valid !== 1'b0 || {overflow, result} !== held) begin n_err++; $display("FAIL drain got %b %h want 0 %h", out_valid, {overflow, result}, held); end
    endtask

    task automatic test_reset_mid_mul;
        int lat, nb;
        logic [32:0] got, exp;
        in_valid = 1'b1; op = 5'd7; a = 32'hdeadbeef; b = 32'h12345679; out_ready = 1'b1;
        sb.push_back(model(7, a, b));
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        n_vec++; if (busy !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin n_err++; $display("FAIL arst_ctrl got busy=%b ov=%b ir=%b want 0 0 1", busy, out_valid, in_ready); end
        n_vec++; if ({overflow, result} !== 33'h0) begin n_err++; $display("FAIL arst_result got %h want 0", {overflow, result}); end
        void'(sb.pop_front());
        @(negedge clk);
        rst = 1'b0;
        run_op(5, 32'h1, 32'h1, lat, nb, got);
        exp = sb.pop_front();
        n_vec++; if (lat !== 1 || got !== {1'b0, 32'h2} || got !== exp) begin n_err++; $display("FAIL post_rst_addu got %0d %h want 1 %h", lat, got, exp); end
    endtask

    initial begin
        test_reset;
        test_single_cycle;
        test_mul;
        test_back_to_back;
        test_reset_mid_mul;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
